// File: rtl/snake_body_engine.sv
// snake_body_engine
// -----------------------------------------------------------------------------
// Datapath for the snake game. Holds the body segment positions and the apple
// cell. Generates the event levels and pulses used by the controller. Also
// serves combinational pixel queries for the renderer.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   ld                move enable from the controller
//   tick              one-cycle step strobe from the speed divider
//   dir               requested direction: 00 up, 01 right, 10 down, 11 left
//   length            extra segments beyond the head (active = length+1, capped)
//   head              registered pulse, one cycle after a committed step
//   apple             head is on the apple and no relocation is pending
//   border            head is on an edge cell
//   gameOver          sticky collision flag, cleared only by reset
//   head_x/head_y     head coordinates
//   apple_x/apple_y   apple coordinates
//   q_x/q_y           renderer query cell
//   q_body/q_apple    query cell holds an active segment / the apple
// -----------------------------------------------------------------------------
module snake_body_engine #(
  parameter int         GRID_W  = 8,
  parameter int         GRID_H  = 8,
  parameter int         COORD_W = 3,
  parameter int         MAX_SEG = 8,
  parameter logic [7:0] SEED    = 8'hA5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld,
  input  logic               tick,
  input  logic [1:0]         dir,
  input  logic [2:0]         length,
  output logic               head,
  output logic               apple,
  output logic               border,
  output logic               gameOver,
  output logic [COORD_W-1:0] head_x,
  output logic [COORD_W-1:0] head_y,
  output logic [COORD_W-1:0] apple_x,
  output logic [COORD_W-1:0] apple_y,
  input  logic [COORD_W-1:0] q_x,
  input  logic [COORD_W-1:0] q_y,
  output logic               q_body,
  output logic               q_apple
);

  // Coordinates are widened by one bit. A step off the low edge then wraps to
  // a large value, so a single unsigned compare catches both edges.
  localparam logic [COORD_W:0]   GW_C      = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0]   GH_C      = (COORD_W+1)'(GRID_H);
  localparam logic [COORD_W-1:0] CX_C      = COORD_W'(GRID_W / 2);
  localparam logic [COORD_W-1:0] CY_C      = COORD_W'(GRID_H / 2);
  localparam logic [COORD_W-1:0] AX_C      = COORD_W'(GRID_W - 2);
  localparam logic [COORD_W-1:0] AY_C      = COORD_W'(1);
  localparam logic [COORD_W-1:0] XMAX_C    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMAX_C    = COORD_W'(GRID_H - 1);
  localparam logic [7:0]         MAX_SEG_C = 8'(MAX_SEG);

  // State
  logic [COORD_W-1:0] seg_x_q [MAX_SEG];
  logic [COORD_W-1:0] seg_y_q [MAX_SEG];
  logic [COORD_W-1:0] seg_x_d [MAX_SEG];
  logic [COORD_W-1:0] seg_y_d [MAX_SEG];
  logic [1:0]         dir_q, dir_d;
  logic [COORD_W-1:0] apple_x_q, apple_x_d;
  logic [COORD_W-1:0] apple_y_q, apple_y_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               head_q, head_d;
  logic               game_over_q, game_over_d;
  logic               reloc_q, reloc_d;
  logic [2:0]         len_sh_q, len_sh_d;

  // Combinational helpers
  logic [7:0]         len_p1;
  logic [7:0]         nseg;
  logic [COORD_W:0]   nxt_x, nxt_y;
  logic               border_hit, self_hit;
  logic               step_try, step_ok;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic               cand_on_body, cand_ok, reloc_commit;

  // Active segment count
  always_comb begin
    len_p1 = {5'd0, length} + 8'd1;
    nseg   = (len_p1 > MAX_SEG_C) ? MAX_SEG_C : len_p1;
  end

  // Step evaluation
  always_comb begin
    nxt_x = {1'b0, seg_x_q[0]};
    nxt_y = {1'b0, seg_y_q[0]};
    unique case (dir_q)
      2'b00:   nxt_y = {1'b0, seg_y_q[0]} - 1'b1;
      2'b01:   nxt_x = {1'b0, seg_x_q[0]} + 1'b1;
      2'b10:   nxt_y = {1'b0, seg_y_q[0]} + 1'b1;
      default: nxt_x = {1'b0, seg_x_q[0]} - 1'b1;
    endcase

    border_hit = (nxt_x >= GW_C) || (nxt_y >= GH_C);

    // The tail is excluded, because it vacates its cell during the same step.
    self_hit = 1'b0;
    for (int k = 0; k < MAX_SEG - 1; k++) begin
      if ((8'(k) + 8'd1 < nseg) &&
          (seg_x_q[k] == nxt_x[COORD_W-1:0]) &&
          (seg_y_q[k] == nxt_y[COORD_W-1:0])) begin
        self_hit = 1'b1;
      end
    end

    step_try = tick && ld && !game_over_q;
    step_ok  = step_try && !border_hit && !self_hit;
  end

  // Apple candidate from the LFSR
  always_comb begin
    cand_x = lfsr_q[COORD_W-1:0];
    cand_y = lfsr_q[2*COORD_W-1:COORD_W];

    cand_on_body = 1'b0;
    for (int k = 0; k < MAX_SEG; k++) begin
      if ((8'(k) < nseg) && (seg_x_q[k] == cand_x) && (seg_y_q[k] == cand_y)) begin
        cand_on_body = 1'b1;
      end
    end

    cand_ok = ({1'b0, cand_x} < GW_C) && ({1'b0, cand_y} < GH_C) && !cand_on_body;
    // Relocation waits for a cycle with no step, so the body it was checked
    // against is the body that remains after the cycle.
    reloc_commit = reloc_q && !step_ok && cand_ok;
  end

  // Next state
  always_comb begin
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    if (step_ok) begin
      for (int k = 1; k < MAX_SEG; k++) begin
        seg_x_d[k] = seg_x_q[k-1];
        seg_y_d[k] = seg_y_q[k-1];
      end
      seg_x_d[0] = nxt_x[COORD_W-1:0];
      seg_y_d[0] = nxt_y[COORD_W-1:0];
    end

    // A direct reversal of the latched direction is ignored.
    dir_d = (dir == (dir_q ^ 2'b10)) ? dir_q : dir;

    head_d      = step_ok;
    game_over_d = game_over_q || (step_try && (border_hit || self_hit));

    len_sh_d = length;
    // A length change that lands in the same cycle as a commit re-arms the
    // relocation, so the newest length always gets a fresh apple.
    if (length != len_sh_q)  reloc_d = 1'b1;
    else if (reloc_commit)   reloc_d = 1'b0;
    else                     reloc_d = reloc_q;

    apple_x_d = reloc_commit ? cand_x : apple_x_q;
    apple_y_d = reloc_commit ? cand_y : apple_y_q;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < MAX_SEG; k++) begin
        seg_x_q[k] <= CX_C;
        seg_y_q[k] <= CY_C;
      end
      dir_q       <= 2'b01;
      apple_x_q   <= AX_C;
      apple_y_q   <= AY_C;
      lfsr_q      <= SEED;
      head_q      <= 1'b0;
      game_over_q <= 1'b0;
      reloc_q     <= 1'b0;
      len_sh_q    <= 3'd0;
    end else begin
      for (int k = 0; k < MAX_SEG; k++) begin
        seg_x_q[k] <= seg_x_d[k];
        seg_y_q[k] <= seg_y_d[k];
      end
      dir_q       <= dir_d;
      apple_x_q   <= apple_x_d;
      apple_y_q   <= apple_y_d;
      lfsr_q      <= lfsr_d;
      head_q      <= head_d;
      game_over_q <= game_over_d;
      reloc_q     <= reloc_d;
      len_sh_q    <= len_sh_d;
    end
  end

  // Outputs
  always_comb begin
    head     = head_q;
    gameOver = game_over_q;
    head_x   = seg_x_q[0];
    head_y   = seg_y_q[0];
    apple_x  = apple_x_q;
    apple_y  = apple_y_q;
    border   = (seg_x_q[0] == '0) || (seg_x_q[0] == XMAX_C) ||
               (seg_y_q[0] == '0) || (seg_y_q[0] == YMAX_C);
    apple    = (apple_x_q == seg_x_q[0]) && (apple_y_q == seg_y_q[0]) && !reloc_q;

    q_apple = (q_x == apple_x_q) && (q_y == apple_y_q);
    q_body  = 1'b0;
    for (int k = 0; k < MAX_SEG; k++) begin
      if ((8'(k) < nseg) && (seg_x_q[k] == q_x) && (seg_y_q[k] == q_y)) begin
        q_body = 1'b1;
      end
    end
  end

endmodule

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
Datapath partner of the snake game control unit. It owns the snake's body positions and the apple position on the playfield grid. It also generates the event signals the controller consumes: head step, apple at head, border contact and game over. It consumes the controller's `ld` move-enable and `length` count, and gives the VGA renderer a combinational pixel query port.

Parameters:
GRID_W, 8, playfield width in cells
GRID_H, 8, playfield height in cells
COORD_W, 3, coordinate width; 2**COORD_W >= max(GRID_W, GRID_H)
MAX_SEG, 8, maximum number of body segments stored
SEED, 8'hA5, LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ld  in  1  move enable from the controller
tick  in  1  one-cycle step strobe from the game-speed divider
dir  in  2  requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
length  in  3  extra segments from the controller
head  out  1  one-cycle pulse, registered, in the cycle after a committed step
apple  out  1  level: apple cell equals head cell and no relocation is pending
border  out  1  level: head on any edge cell
gameOver  out  1  sticky collision flag
head_x, head_y  out  COORD_W  head coordinates
apple_x, apple_y  out  COORD_W  apple coordinates
q_x, q_y  in  COORD_W  renderer query cell
q_body, q_apple  out  1  combinational: query cell holds an active segment / holds the apple

Behaviour:
Reset values, all taken on the next clk edge after reset=1:
- Every segment is at (GRID_W/2, GRID_H/2); with defaults that is (4,4).
- Latched direction is right (01).
- Apple is at (GRID_W-2, 1); with defaults that is (6,1).
- LFSR is SEED.
- head=0, gameOver=0, relocation-pending=0, length shadow register is 0.
- Reset takes priority over everything, including mid-step and mid-relocation.

Segment count:
- nseg = min(length+1, MAX_SEG), derived combinationally from length.
- seg[0] is the head. Only segments 0..nseg-1 are active.

Direction:
- The latch takes dir every cycle.
- A request that is the exact reverse of the latched direction is ignored.

Step:
- A step is attempted in a cycle where tick && ld && !gameOver.
- nxt = head + delta of the latched direction.
- Border collision: if nxt is outside [0,GRID_W-1]x[0,GRID_H-1], set gameOver. Segments do not move.
- Self collision: if nxt equals any seg[k] for k in 0..nseg-2, set gameOver and do not move. The tail, seg[nseg-1], is excluded because it vacates in the same step.
- Otherwise commit: seg[k] <= seg[k-1] for k=1..MAX_SEG-1, and seg[0] <= nxt. Head pulses on the next cycle.
- Inactive segments shift as well, so a segment that becomes active on growth holds the prior tail position.
- A colliding step gives no head pulse.

gameOver:
- Once set, it stays set until reset.
- All further steps are blocked.

Apple relocation:
- The length shadow register updates every cycle.
- length != shadow sets relocation-pending.
- The LFSR advances every cycle: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
- Candidate cell: x = lfsr[COORD_W-1:0], y = lfsr[2*COORD_W-1:COORD_W].
- A candidate is rejected if x>=GRID_W, y>=GRID_H, or it matches an active segment.
- While pending, a candidate commits only in a cycle with no committed step. Commit writes apple_x/apple_y and clears pending.
- If a commit does not happen, retry next cycle. apple_x/apple_y hold their old value until commit.

Outputs:
- border and the q_* outputs are combinational from registered state.

Test Plan:
- Reset, ld=1, dir=01, 3 ticks -> head_x 5,6,7 with head_y=4. One head pulse one cycle after each tick. border=1 at x=7. 4th tick -> gameOver=1, head_x stays 7, no head pulse.
- Moving right, dir=11 held, 1 tick -> head_x increments (reversal ignored). Then dir=10, 1 tick -> head_y increments.
- From reset: dir=00 for 3 ticks, then dir=01 for 2 ticks -> head=(6,1) and apple=1 with the 5th head pulse. Set length 0->1 -> within a few cycles apple moves to a cell not on the body, apple=0, and q_apple is 1 at the new apple_x/apple_y.
- length=4 (nseg=5), tick path right, down, left, up -> 4th tick sets gameOver. Repeat with length=3 (nseg=4) -> no gameOver, and the head returns to its starting cell.
- ld=0 with 3 ticks -> no movement and no head pulse.
- Assert reset mid-run after gameOver -> next edge: head=(4,4), apple=(6,1), gameOver=0. q_body=1 only at (4,4).
